// File: rtl/audio_sample_streamer.sv
// Audio playback path: sample FIFO, sample-rate pacer, prime/play/underrun sequencer,
// attenuation stage and PWM output for AUD_PWM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | playback disabled, output parked at midscale, FIFO retained
// PRIME    | waiting for FIFO fill to reach PRIME_LEVEL
// PLAY     | one sample popped per pacer pulse
// UNDERRUN | FIFO ran dry on a pacer pulse; single cycle, back to PRIME
module audio_sample_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 2048,
    parameter int PRIME_LEVEL = 256
) (
    input  logic                    clk_100mhz,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    flush,
    input  logic                    enable,
    input  logic                    mute,
    input  logic [2:0]              atten,
    input  logic [15:0]             rate_div,
    output logic [DATA_WIDTH-1:0]   sample_out,
    output logic                    sample_tick,
    output logic                    pwm_out,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    empty,
    output logic                    playing,
    output logic [15:0]             underrun_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_C = (AW+1)'(PRIME_LEVEL);
    localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY,
        S_UNDERRUN
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  full, push, pop, underrun_hit;

    logic [15:0]           pace_cnt, div_q, div_eff;
    logic                  pace;

    logic [DATA_WIDTH-1:0] rd_sample, scaled;
    logic signed [DATA_WIDTH-1:0] diff, shifted;
    logic [DATA_WIDTH-1:0] pwm_cnt;

    assign full       = (count == DEPTH_C);
    assign push       = wr_valid & ~full & ~flush;
    assign wr_ready   = ~full;
    assign fifo_count = count;
    assign empty      = (count == '0);
    assign playing    = (state == S_PLAY);
    assign rd_sample  = mem[rd_ptr];

    // ---------------- FIFO ----------------
    always_ff @(posedge clk_100mhz) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- pacer ----------------
    // Period is latched at each wrap so a rate change never truncates a sample slot.
    assign div_eff = (rate_div < 16'd2) ? 16'd2 : rate_div;
    assign pace    = (pace_cnt == div_q - 16'd1);

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            pace_cnt <= '0;
            div_q    <= div_eff;
        end else if (pace) begin
            pace_cnt <= '0;
            div_q    <= div_eff;
        end else begin
            pace_cnt <= pace_cnt + 16'd1;
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        underrun_hit = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
        end else if (flush) begin
            state_next = S_PRIME;
        end else begin
            case (state)
                S_IDLE:  state_next = S_PRIME;
                S_PRIME: if (count >= PRIME_C) state_next = S_PLAY;
                S_PLAY: begin
                    if (pace) begin
                        if (count != '0) begin
                            pop = 1'b1;
                        end else begin
                            underrun_hit = 1'b1;
                            state_next   = S_UNDERRUN;
                        end
                    end
                end
                S_UNDERRUN: state_next = S_PRIME;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (underrun_hit && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

    // ---------------- attenuation ----------------
    // s - MID always fits DATA_WIDTH signed bits (flip the MSB); adding MID back is the
    // same MSB flip, so the result is exact with no saturation needed.
    always_comb begin
        diff    = $signed({~rd_sample[DATA_WIDTH-1], rd_sample[DATA_WIDTH-2:0]});
        shifted = diff >>> atten;
        scaled  = {~shifted[DATA_WIDTH-1], shifted[DATA_WIDTH-2:0]};
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            sample_out  <= MID;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= 1'b0;
            if (state_next != S_PLAY) begin
                sample_out <= MID;
            end else if (pop) begin
                sample_out  <= mute ? MID : scaled;
                sample_tick <= 1'b1;
            end
        end
    end

    // ---------------- PWM ----------------
    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DATA_WIDTH'(1);
            pwm_out <= (pwm_cnt < sample_out);
        end
    end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Self-checking bench for audio_sample_streamer: table of attenuation vectors plus
// multi-cycle sequences; every output tick is scored against a queue of expected samples.
module tb_audio_sample_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        flush;
    logic        enable;
    logic        mute;
    logic [2:0]  atten;
    logic [15:0] rate_div;
    logic [7:0]  sample_out;
    logic        sample_tick;
    logic        pwm_out;
    logic [11:0] fifo_count;
    logic        empty;
    logic        playing;
    logic [15:0] underrun_count;

    audio_sample_streamer #(.DATA_WIDTH(8), .DEPTH(2048), .PRIME_LEVEL(256)) dut (
        .clk_100mhz     (clk),
        .reset_n        (reset_n),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .flush          (flush),
        .enable         (enable),
        .mute           (mute),
        .atten          (atten),
        .rate_div       (rate_div),
        .sample_out     (sample_out),
        .sample_tick    (sample_tick),
        .pwm_out        (pwm_out),
        .fifo_count     (fifo_count),
        .empty          (empty),
        .playing        (playing),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sample;
        logic [2:0] atten;
        logic       mute;
        logic [7:0] expected;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] exp_q [$];
    int         checks   = 0;
    int         errors   = 0;
    int         tick_cnt = 0;
    int         cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: each output tick must match the oldest expected sample.
    always @(negedge clk) begin
        if (sample_tick) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick actual=%0d required=none", sample_out);
            end else begin
                check("tick_sample_out", sample_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int target, input int budget, input string name);
        int n = 0;
        while (tick_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (tick_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s timeout ticks=%0d required=%0d", name, tick_cnt, target);
        end
    endtask

    task automatic push_one(input logic [7:0] d, input logic [7:0] e);
        wr_data  = d;
        wr_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic push_seq(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = 8'(base + i * step);
            wr_data  = d;
            wr_valid = 1'b1;
            exp_q.push_back(d);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sample_out"}, sample_out, 8'h80);
        check({tag, "_sample_tick"}, sample_tick, 0);
        check({tag, "_pwm_out"}, pwm_out, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_underrun_count"}, underrun_count, 0);
    endtask

    initial begin
        int base, last, n, hi;

        vecs[0]  = '{8'hFF, 3'd2, 1'b0, 8'h9F};
        vecs[1]  = '{8'h00, 3'd2, 1'b0, 8'h60};
        vecs[2]  = '{8'hFF, 3'd0, 1'b0, 8'hFF};
        vecs[3]  = '{8'h00, 3'd0, 1'b0, 8'h00};
        vecs[4]  = '{8'h80, 3'd3, 1'b0, 8'h80};
        vecs[5]  = '{8'hC0, 3'd1, 1'b0, 8'hA0};
        vecs[6]  = '{8'h40, 3'd1, 1'b0, 8'h60};
        vecs[7]  = '{8'hFF, 3'd7, 1'b0, 8'h80};
        vecs[8]  = '{8'h00, 3'd7, 1'b0, 8'h7F};
        vecs[9]  = '{8'h01, 3'd3, 1'b0, 8'h70};
        vecs[10] = '{8'hFF, 3'd2, 1'b1, 8'h80};
        vecs[11] = '{8'h00, 3'd2, 1'b1, 8'h80};
        vecs[12] = '{8'h37, 3'd0, 1'b1, 8'h80};

        // Reset with a write request held: nothing may land in the FIFO.
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        flush    = 1'b0;
        enable   = 1'b0;
        mute     = 1'b0;
        atten    = 3'd0;
        rate_div = 16'd4;
        repeat (3) tick();
        check_reset_values("reset");
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        check("write_dropped_in_reset", fifo_count, 0);

        // Prime and play at rate_div=4.
        push_seq(300, 0, 1);
        check("t1_count_after_fill", fifo_count, 300);
        check("t1_idle_not_playing", playing, 0);
        enable = 1'b1;
        tick();
        check("t1_prime_not_playing", playing, 0);
        tick();
        check("t1_playing", playing, 1);
        base = tick_cnt;
        last = 0;
        for (int k = 1; k <= 8; k++) begin
            wait_ticks(base + k, 20, "t1_tick");
            if (k > 1) check("t1_tick_spacing", cyc - last, 4);
            last = cyc;
            check("t1_count_drop", fifo_count, 300 - k);
        end

        // Drain to underrun.
        n = 0;
        while (underrun_count == 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("underrun_count", underrun_count, 1);
        check("underrun_sample_mid", sample_out, 8'h80);
        check("underrun_not_playing", playing, 0);
        check("underrun_fifo_empty", fifo_count, 0);
        check("underrun_all_scored", exp_q.size(), 0);
        tick();
        push_seq(255, 8'hA0, 1);
        repeat (3) tick();
        check("reprime_255_not_playing", playing, 0);
        check("reprime_count_255", fifo_count, 255);
        push_seq(1, 8'h9F, 0);
        check("reprime_256_pending", playing, 0);
        tick();
        check("reprime_256_playing", playing, 1);

        // Flush in PLAY with a same-cycle write.
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        check("flush_count", fifo_count, 0);
        check("flush_empty", empty, 1);
        check("flush_not_playing", playing, 0);
        check("flush_keeps_underrun", underrun_count, 1);
        tick();
        check("flush_write_refused", fifo_count, 0);

        // Attenuation / mute table; settings change between pops.
        base  = tick_cnt;
        atten = vecs[0].atten;
        mute  = vecs[0].mute;
        for (int i = 0; i < 13; i++) push_one(vecs[i].sample, vecs[i].expected);
        push_seq(243, 0, 0);
        for (int i = 0; i < 13; i++) begin
            wait_ticks(base + i + 1, 20, "table_tick");
            check("table_count_drop", fifo_count, 256 - (i + 1));
            if (i < 12) begin
                atten = vecs[i + 1].atten;
                mute  = vecs[i + 1].mute;
            end
        end
        enable = 1'b0;
        tick();
        check("disable_not_playing", playing, 0);
        check("disable_fifo_retained", fifo_count, 243);
        check("disable_sample_mid", sample_out, 8'h80);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("flush_idle_count", fifo_count, 0);

        // Fill to DEPTH, then pop with a write on the full cycle.
        atten = 3'd0;
        mute  = 1'b0;
        push_seq(2048, 0, 7);
        check("full_count", fifo_count, 2048);
        check("full_wr_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        tick();
        check("full_write_dropped", fifo_count, 2048);
        base   = tick_cnt;
        enable = 1'b1;
        wait_ticks(base + 1, 20, "full_pop_tick");
        check("full_pop_write_refused", fifo_count, 2047);
        wr_valid = 1'b0;
        tick();
        check("full_after_pop_count", fifo_count, 2047);
        check("full_after_pop_ready", wr_ready, 1);
        enable = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();

        // rate_div below 2 clamps to 2; then reset mid-play at count 100.
        rate_div = 16'd1;
        enable   = 1'b1;
        tick();
        push_seq(300, 3, 1);
        base = tick_cnt;
        wait_ticks(base + 1, 10, "d2_tick");
        last = cyc;
        wait_ticks(base + 2, 10, "d2_tick");
        check("d2_tick_spacing", cyc - last, 2);
        n = 0;
        while (fifo_count != 100 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_count_100", fifo_count, 100);
        check("reach_count_playing", playing, 1);
        reset_n = 1'b0;
        tick();
        exp_q.delete();
        check_reset_values("midplay_reset");

        // PWM duty with midscale samples.
        reset_n  = 1'b1;
        rate_div = 16'd4;
        base     = tick_cnt;
        push_seq(256, 8'h80, 0);
        wait_ticks(base + 1, 20, "pwm_tick");
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            #1;
            if (pwm_out) hi++;
        end
        check("pwm_duty_mid", hi, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
